output_demux: RTL and testbench

Stream demultiplexer for the CNN accelerator datapath. It takes one 32-bit valid/ready result stream, for example from the PE array or accumulator, and routes each beat to one of two destinations, such as the feature-map writeback buffer and the next-layer input path. Routing uses the same 2-bit select encoding as the datapath input multiplexer. Each destination has its own 2-entry elastic buffer, and the block keeps per-destination and drop counters for debug.

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_fifo2.sv | 71 +++++++
 rtl/output_demux.sv | 107 ++++++++++
 tb/tb_output_demux.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared select encoding and widths for the datapath mux/demux
package demux_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    localparam logic [1:0] SEL_A = 2'b01;
    localparam logic [1:0] SEL_B = 2'b00;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Codes 10/11 both mean "discard this beat".
    function automatic logic is_drop(input logic [1:0] sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/demux_fifo2.sv
// rtl/demux_fifo2.sv - 2-entry synchronous FIFO with registered head
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // A push while full is only honoured together with a pop.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        occ_d = OCC_ONE;
                    end
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign head_data = head_q;
    assign occ       = occ_q;

endmodule

// File: rtl/output_demux.sv
// rtl/output_demux.sv - routes one result stream to two buffered destinations
module output_demux
    import demux_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  a_cnt,
    output logic [CNT_W-1:0]  b_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] a_occ, b_occ;
    logic       a_push, b_push, a_pop, b_pop, drop_acc;

    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    assign a_valid = (a_occ != 2'd0);
    assign b_valid = (b_occ != 2'd0);
    assign a_pop   = a_valid && a_ready;
    assign b_pop   = b_valid && b_ready;

    // Registered occupancy only: consumer ready never reaches in_ready.
    always_comb begin
        in_ready = 1'b1;
        if (in_sel == SEL_A) begin
            in_ready = (a_occ != 2'd2);
        end else if (in_sel == SEL_B) begin
            in_ready = (b_occ != 2'd2);
        end
    end

    assign a_push   = in_valid && in_ready && (in_sel == SEL_A);
    assign b_push   = in_valid && in_ready && (in_sel == SEL_B);
    assign drop_acc = in_valid && is_drop(in_sel);

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_pop),
        .head_data (a_data),
        .occ       (a_occ)
    );

    demux_fifo2 #(.DATA_W(DATA_W)) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_pop),
        .head_data (b_data),
        .occ       (b_occ)
    );

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        a_cnt_d    = a_cnt_q;
        b_cnt_d    = b_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr_cnt) begin
            a_cnt_d    = '0;
            b_cnt_d    = '0;
            drop_cnt_d = '0;
        end else begin
            if (a_pop && (a_cnt_q != CNT_MAX)) a_cnt_d = a_cnt_q + CNT_ONE;
            if (b_pop && (b_cnt_q != CNT_MAX)) b_cnt_d = b_cnt_q + CNT_ONE;
            if (drop_acc && (drop_cnt_q != CNT_MAX)) drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q    <= '0;
            b_cnt_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            a_cnt_q    <= a_cnt_d;
            b_cnt_q    <= b_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign a_cnt    = a_cnt_q;
    assign b_cnt    = b_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_output_demux.sv
// tb/tb_output_demux.sv - scoreboard bench for output_demux
module tb_output_demux;
    import demux_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    in_sel = 2'b01;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_data, b_data;
    logic          a_valid, b_valid;
    logic          a_ready = 1'b0;
    logic          b_ready = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] a_cnt, b_cnt, drop_cnt;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    bit rand_rdy = 1'b0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [CW-1:0] m_a_cnt = '0, m_b_cnt = '0, m_drop_cnt = '0;

    output_demux #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .clr_cnt  (clr_cnt),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt),
        .drop_cnt (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of the two buffers and counters, advanced just before each rising edge.
    always @(negedge clk) begin : mon
        logic er, pa, pb;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            m_a_cnt    = '0;
            m_b_cnt    = '0;
            m_drop_cnt = '0;
            chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
            chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
            chk("rst_a_data", a_data, 32'd0);
            chk("rst_a_cnt", {16'd0, a_cnt}, 32'd0);
        end else begin
            er = (in_sel == SEL_A) ? (qa.size() < 2) :
                 (in_sel == SEL_B) ? (qb.size() < 2) : 1'b1;
            chk("in_ready", {31'd0, in_ready}, {31'd0, er});
            chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
            chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
            if (qa.size() != 0) chk("a_data", a_data, qa[0]);
            if (qb.size() != 0) chk("b_data", b_data, qb[0]);
            chk("a_cnt", {16'd0, a_cnt}, {16'd0, m_a_cnt});
            chk("b_cnt", {16'd0, b_cnt}, {16'd0, m_b_cnt});
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drop_cnt});
            pa = (qa.size() != 0) && a_ready;
            pb = (qb.size() != 0) && b_ready;
            if (pa) begin void'(qa.pop_front()); delivered++; end
            if (pb) begin void'(qb.pop_front()); delivered++; end
            if (clr_cnt) begin
                m_a_cnt    = '0;
                m_b_cnt    = '0;
                m_drop_cnt = '0;
            end else begin
                if (pa && m_a_cnt != '1) m_a_cnt++;
                if (pb && m_b_cnt != '1) m_b_cnt++;
            end
            if (in_valid && er) begin
                if (in_sel == SEL_A) qa.push_back(in_data);
                else if (in_sel == SEL_B) qb.push_back(in_data);
                else if (!clr_cnt && m_drop_cnt != '1) m_drop_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] s);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        checks++;
        errors++;
        $error("FAIL send_timeout: observed=stalled expected=accepted data=%h", d);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (qa.size() == 0 && qb.size() == 0) return;
            step();
        end
        checks++;
        errors++;
        $error("FAIL drain_timeout: observed=%0d/%0d expected=0/0", qa.size(), qb.size());
    endtask

    initial begin
        repeat (3) step();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        // single beat to A
        a_ready = 1'b1;
        send(32'hDEAD0001, 2'b01);
        chk("first_a_valid", {31'd0, a_valid}, 32'd1);
        chk("first_a_data", a_data, 32'hDEAD0001);
        step();
        chk("first_a_cnt", {16'd0, a_cnt}, 32'd1);
        chk("first_b_valid", {31'd0, b_valid}, 32'd0);

        // fill A, third beat stalls, including the cycle of the first pop
        a_ready = 1'b0;
        send(32'h1, 2'b01);
        send(32'h2, 2'b01);
        in_data = 32'h3; in_sel = 2'b01; in_valid = 1'b1;
        @(negedge clk);
        chk("full_stall", {31'd0, in_ready}, 32'd0);
        step();
        a_ready = 1'b1;
        @(negedge clk);
        chk("no_full_bypass", {31'd0, in_ready}, 32'd0);
        step();
        send(32'h3, 2'b01);
        drain();

        // B proceeds while A is full
        a_ready = 1'b0;
        b_ready = 1'b0;
        send(32'hA1, 2'b01);
        send(32'hA2, 2'b01);
        send(32'hB1, 2'b00);
        chk("hol_b_valid", {31'd0, b_valid}, 32'd1);
        chk("hol_b_data", b_data, 32'hB1);
        chk("hol_a_data", a_data, 32'hA1);
        drain();

        // drops under random ready
        rand_rdy = 1'b1;
        send(32'hD0, 2'b10);
        send(32'hD1, 2'b11);
        rand_rdy = 1'b0;
        drain();
        chk("drop_cnt", {16'd0, drop_cnt}, 32'd2);
        chk("drop_no_valid", {30'd0, a_valid, b_valid}, 32'd0);

        // clear beats a same-cycle output handshake
        a_ready = 1'b1;
        send(32'hC0, 2'b01);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk("clr_prio_a_cnt", {16'd0, a_cnt}, 32'd0);
        drain();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        delivered = 0;

        // 100 alternating beats with random ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) send(32'hA000_0000 + i, 2'b01);
            else            send(32'hB000_0000 + i, 2'b00);
        end
        rand_rdy = 1'b0;
        drain();
        step();
        chk("stream_cnt_sum", 32'(a_cnt) + 32'(b_cnt), 32'd100);
        chk("stream_delivered", delivered, 32'd100);

        // async reset with both buffers full
        a_ready = 1'b0;
        b_ready = 1'b0;
        send(32'h11, 2'b01);
        send(32'h12, 2'b01);
        send(32'h21, 2'b00);
        send(32'h22, 2'b00);
        chk("pre_rst_valids", {30'd0, a_valid, b_valid}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valids", {30'd0, a_valid, b_valid}, 32'd0);
        chk("async_rst_b_cnt", {16'd0, b_cnt}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        a_ready = 1'b1;
        send(32'hCAFE0001, 2'b01);
        chk("post_rst_a_data", a_data, 32'hCAFE0001);
        drain();
        step();
        chk("post_rst_a_cnt", {16'd0, a_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
